// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - memory-stage op encodings, FSM states and decode helper
package mem_access_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] MINST_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  // Unlisted funct3 values fall back to "no memory op" so they pass through.
  function automatic logic is_mem_op(input logic [3:0] minst);
    if (minst[3:2] == MINST_NONE) return 1'b0;
    if (minst[3]) return (minst[2:0] == SB) || (minst[2:0] == SH) || (minst[2:0] == SW);
    return (minst[2:0] == LB) || (minst[2:0] == LH) || (minst[2:0] == LW) ||
           (minst[2:0] == LBU) || (minst[2:0] == LHU);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - single-outstanding request/grant/response data bus
interface mem_access_if;

  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic        dgnt;
  logic        drvalid;
  logic [31:0] drdata;

  modport master (
    output dreq, dwe, daddr, dbe, dwdata,
    input  dgnt, drvalid, drdata
  );

  modport slave (
    input  dreq, dwe, daddr, dbe, dwdata,
    output dgnt, drvalid, drdata
  );

endinterface

// File: rtl/mem_access_align.sv
// rtl/mem_access_align.sv - byte-lane steering for stores and extract/extend for loads
module mem_access_align
  import mem_access_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic        st_misalign_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // Store side is also used for load masks, so funct3[2] (unsigned) is ignored here.
  always_comb begin
    st_be_o       = 4'hF;
    st_misalign_o = 1'b0;
    st_wdata_o    = st_wdata_i << {st_off_i, 3'b000};
    case (st_funct3_i[1:0])
      2'b00: st_be_o = 4'b0001 << st_off_i;
      2'b01: begin
        st_be_o       = 4'b0011 << st_off_i;
        st_misalign_o = st_off_i[0];
      end
      default: st_misalign_o = (st_off_i != 2'b00);
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    case (ld_funct3_i)
      LB:      ld_data_o = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LH:      ld_data_o = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LBU:     ld_data_o = {24'h0, ld_shifted[7:0]};
      LHU:     ld_data_o = {16'h0, ld_shifted[15:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory stage: bus master FSM, writeback and misalign pulse
module mem_access
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       minst_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [4:0]       rd_i,
  input  logic             rdm_v_i,
  output logic             stall_o,
  mem_access_if.master     dbus,
  output logic             wb_v_o,
  output logic [4:0]       wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             misalign_o
);

  mem_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, dwdata_q, wb_data_q;
  logic [3:0]      dbe_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q, wb_rd_q;
  logic            dwe_q, wb_v_q, misalign_q;

  logic            mem_op;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic            st_misalign;

  assign mem_op = is_mem_op(minst_i);

  mem_access_align u_align (
    .st_funct3_i   (minst_i[2:0]),
    .st_off_i      (addr_i[1:0]),
    .st_wdata_i    (wdata_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .st_misalign_o (st_misalign),
    .ld_funct3_i   (funct3_q),
    .ld_off_i      (addr_q[1:0]),
    .ld_rdata_i    (dbus.drdata),
    .ld_data_o     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      dwdata_q   <= '0;
      dbe_q      <= '0;
      dwe_q      <= 1'b0;
      funct3_q   <= '0;
      rd_q       <= '0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_v_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (st_misalign) begin
              misalign_q <= 1'b1;
            end else begin
              addr_q   <= addr_i;
              dwdata_q <= st_wdata;
              dbe_q    <= st_be;
              dwe_q    <= minst_i[3];
              funct3_q <= minst_i[2:0];
              rd_q     <= rd_i;
            end
          end else if (rdm_v_i && (rd_i != 5'd0)) begin
            wb_v_q    <= 1'b1;
            wb_rd_q   <= rd_i;
            wb_data_q <= addr_i;
          end
        end
        RESP: begin
          if (dbus.drvalid && (rd_q != 5'd0)) begin
            wb_v_q    <= 1'b1;
            wb_rd_q   <= rd_q;
            wb_data_q <= ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op && !st_misalign) state_d = REQ;
      REQ:     if (dbus.dgnt) state_d = dwe_q ? IDLE : RESP;
      RESP:    if (dbus.drvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_o     = (state_q != IDLE);
    dbus.dreq   = (state_q == REQ);
    dbus.dwe    = dwe_q;
    dbus.daddr  = {addr_q[XLEN-1:2], 2'b00};
    dbus.dbe    = dbe_q;
    dbus.dwdata = dwdata_q;
    wb_v_o      = wb_v_q;
    wb_rd_o     = wb_rd_q;
    wb_data_o   = wb_data_q;
    misalign_o  = misalign_q;
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - vector table plus writeback scoreboard for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  minst;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        rdm_v;
  logic        stall_o, wb_v_o, misalign_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  int          checks = 0;
  int          errors = 0;

  mem_access_if dbus ();

  mem_access dut (
    .clk        (clk),
    .reset      (reset),
    .minst_i    (minst),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rd_i       (rd),
    .rdm_v_i    (rdm_v),
    .stall_o    (stall_o),
    .dbus       (dbus),
    .wb_v_o     (wb_v_o),
    .wb_rd_o    (wb_rd_o),
    .wb_data_o  (wb_data_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  minst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        rdm_v;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        exp_mis;
    logic        exp_req;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_dbe;
    logic [31:0] exp_dwdata;
    logic        exp_wb;
    logic [31:0] exp_wbdata;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  vec_t vecs[15];
  wb_t  sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wb_v_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected actual rd=%0d data=%h required none", wb_rd_o, wb_data_o);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        chk("sb_wb_rd", {27'h0, wb_rd_o}, {27'h0, e.rd});
        chk("sb_wb_data", wb_data_o, e.data);
      end
    end
  end

  task automatic nop_inputs();
    minst = 4'b1100;
    addr  = 32'h0;
    wdata = 32'h0;
    rd    = 5'd0;
    rdm_v = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    chk("stall_before", {31'h0, stall_o}, 32'h0);
    minst = v.minst;
    addr  = v.addr;
    wdata = v.wdata;
    rd    = v.rd;
    rdm_v = v.rdm_v;
    if (v.exp_wb) sb_q.push_back('{v.rd, v.exp_wbdata});
    @(posedge clk); #1;
    nop_inputs();
    chk("misalign", {31'h0, misalign_o}, {31'h0, v.exp_mis});
    if (v.exp_req) begin
      for (int n = 0; n <= v.gnt_dly; n++) begin
        chk("dreq_hold", {31'h0, dbus.dreq}, 32'h1);
        chk("stall_req", {31'h0, stall_o}, 32'h1);
        chk("daddr", dbus.daddr, v.exp_daddr);
        chk("dbe", {28'h0, dbus.dbe}, {28'h0, v.exp_dbe});
        chk("dwe", {31'h0, dbus.dwe}, {31'h0, v.minst[3]});
        if (v.minst[3]) chk("dwdata", dbus.dwdata, v.exp_dwdata);
        dbus.drvalid = (n < v.gnt_dly);
        dbus.drdata  = 32'h5A5A5A5A;
        dbus.dgnt    = (n == v.gnt_dly);
        @(posedge clk); #1;
        dbus.dgnt    = 1'b0;
        dbus.drvalid = 1'b0;
      end
      chk("dreq_drop", {31'h0, dbus.dreq}, 32'h0);
      if (!v.minst[3]) begin
        chk("stall_resp", {31'h0, stall_o}, 32'h1);
        dbus.drvalid = 1'b1;
        dbus.drdata  = v.rdata;
        @(posedge clk); #1;
        dbus.drvalid = 1'b0;
      end
      chk("stall_done", {31'h0, stall_o}, 32'h0);
    end else begin
      chk("dreq_none", {31'h0, dbus.dreq}, 32'h0);
      chk("stall_none", {31'h0, stall_o}, 32'h0);
    end
    chk("wb_v", {31'h0, wb_v_o}, {31'h0, v.exp_wb});
  endtask

  initial begin
    vecs[0]  = '{4'b1100, 32'h12345678, 32'h0, 5'd5, 1'b1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h12345678};
    vecs[1]  = '{4'b1100, 32'h00000042, 32'h0, 5'd0, 1'b1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[2]  = '{4'b0000, 32'h00001003, 32'h0, 5'd3, 1'b1, 32'h80112233, 0, 1'b0, 1'b1, 32'h00001000, 4'b1000, 32'h0, 1'b1, 32'hFFFFFF80};
    vecs[3]  = '{4'b0100, 32'h00001003, 32'h0, 5'd3, 1'b1, 32'h80112233, 0, 1'b0, 1'b1, 32'h00001000, 4'b1000, 32'h0, 1'b1, 32'h00000080};
    vecs[4]  = '{4'b1001, 32'h00002002, 32'h0000ABCD, 5'd0, 1'b0, 32'h0, 3, 1'b0, 1'b1, 32'h00002000, 4'b1100, 32'hABCD0000, 1'b0, 32'h0};
    vecs[5]  = '{4'b0010, 32'h00001001, 32'h0, 5'd2, 1'b1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[6]  = '{4'b0010, 32'h00003000, 32'h0, 5'd7, 1'b1, 32'hDEADBEEF, 1, 1'b0, 1'b1, 32'h00003000, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF};
    vecs[7]  = '{4'b1100, 32'hCAFEF00D, 32'h0, 5'd9, 1'b1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D};
    vecs[8]  = '{4'b0001, 32'h00004002, 32'h0, 5'd4, 1'b1, 32'h80011234, 0, 1'b0, 1'b1, 32'h00004000, 4'b1100, 32'h0, 1'b1, 32'hFFFF8001};
    vecs[9]  = '{4'b0101, 32'h00004000, 32'h0, 5'd4, 1'b1, 32'h8001F234, 0, 1'b0, 1'b1, 32'h00004000, 4'b0011, 32'h0, 1'b1, 32'h0000F234};
    vecs[10] = '{4'b1000, 32'h00005001, 32'h000000A5, 5'd0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00005000, 4'b0010, 32'h0000A500, 1'b0, 32'h0};
    vecs[11] = '{4'b1010, 32'h00006000, 32'h11223344, 5'd0, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h00006000, 4'hF, 32'h11223344, 1'b0, 32'h0};
    vecs[12] = '{4'b1001, 32'h00002001, 32'h0000FFFF, 5'd0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{4'b0010, 32'h00007000, 32'h0, 5'd0, 1'b1, 32'h13579BDF, 0, 1'b0, 1'b1, 32'h00007000, 4'hF, 32'h0, 1'b0, 32'h0};
    vecs[14] = '{4'b0011, 32'h0000ABCD, 32'h0, 5'd6, 1'b1, 32'h0, 0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0000ABCD};

    reset        = 1'b1;
    nop_inputs();
    dbus.dgnt    = 1'b0;
    dbus.drvalid = 1'b0;
    dbus.drdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_dreq", {31'h0, dbus.dreq}, 32'h0);
    chk("rst_dwe", {31'h0, dbus.dwe}, 32'h0);
    chk("rst_daddr", dbus.daddr, 32'h0);
    chk("rst_dbe", {28'h0, dbus.dbe}, 32'h0);
    chk("rst_wb_v", {31'h0, wb_v_o}, 32'h0);
    chk("rst_wb_data", wb_data_o, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) do_op(vecs[i]);

    // Back-to-back: pass-through op waits behind an in-flight load.
    minst = 4'b0010; addr = 32'h00003000; rd = 5'd7; rdm_v = 1'b1;
    sb_q.push_back('{5'd7, 32'hDEADBEEF});
    @(posedge clk); #1;
    minst = 4'b1100; addr = 32'h00000055; rd = 5'd8; rdm_v = 1'b1;
    sb_q.push_back('{5'd8, 32'h00000055});
    chk("b2b_stall_req", {31'h0, stall_o}, 32'h1);
    dbus.dgnt = 1'b1;
    @(posedge clk); #1;
    dbus.dgnt = 1'b0;
    chk("b2b_stall_resp", {31'h0, stall_o}, 32'h1);
    chk("b2b_no_wb", {31'h0, wb_v_o}, 32'h0);
    dbus.drvalid = 1'b1; dbus.drdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    dbus.drvalid = 1'b0;
    chk("b2b_wb1_v", {31'h0, wb_v_o}, 32'h1);
    chk("b2b_wb1_data", wb_data_o, 32'hDEADBEEF);
    chk("b2b_idle", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    nop_inputs();
    chk("b2b_wb2_v", {31'h0, wb_v_o}, 32'h1);
    chk("b2b_wb2_data", wb_data_o, 32'h00000055);
    @(posedge clk); #1;

    // Reset while waiting for load data, then a stale response.
    minst = 4'b0000; addr = 32'h00008001; rd = 5'd11; rdm_v = 1'b1;
    @(posedge clk); #1;
    nop_inputs();
    dbus.dgnt = 1'b1;
    @(posedge clk); #1;
    dbus.dgnt = 1'b0;
    chk("rm_stall_resp", {31'h0, stall_o}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rm_stall", {31'h0, stall_o}, 32'h0);
    chk("rm_dreq", {31'h0, dbus.dreq}, 32'h0);
    chk("rm_daddr", dbus.daddr, 32'h0);
    chk("rm_dbe", {28'h0, dbus.dbe}, 32'h0);
    chk("rm_dwdata", dbus.dwdata, 32'h0);
    chk("rm_wb_rd", {27'h0, wb_rd_o}, 32'h0);
    dbus.drvalid = 1'b1; dbus.drdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dbus.drvalid = 1'b0;
    chk("rm_late_wb", {31'h0, wb_v_o}, 32'h0);
    chk("rm_late_stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("rm_late_wb2", {31'h0, wb_v_o}, 32'h0);

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the in-order RV32I pipeline, directly after the execution stage.
- Consumes the execution stage's memory-op code, effective address/ALU result and store data.
- Drives a single-outstanding request/grant/response data-bus master, aligns and sign-extends load data, and produces the register writeback.
- Non-memory results flagged for writeback pass through with 1-cycle latency. Stalls the pipeline while a bus transaction is in flight.

Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- minst_i  in  4  op code: [3]=store, [2:0]=funct3; [3:2]==2'b11 means no memory op
- addr_i  in  32  effective address (mem op) or ALU result (pass-through)
- wdata_i  in  32  store data (rs2 value)
- rd_i  in  5  destination register
- rdm_v_i  in  1  writeback requested for this op
- stall_o  out  1  stage busy; upstream holds its op
- dreq_o  out  1  bus request
- dwe_o  out  1  1=write
- daddr_o  out  32  word address, addr[1:0] forced to 0
- dbe_o  out  4  byte enables
- dwdata_o  out  32  lane-shifted store data
- dgnt_i  in  1  request accepted this cycle
- drvalid_i  in  1  read data valid
- drdata_i  in  32  read word
- wb_v_o  out  1  writeback valid (1-cycle pulse)
- wb_rd_o  out  5  writeback register
- wb_data_o  out  32  writeback data
- misalign_o  out  1  misaligned access pulse

Behaviour:
- Reset values: state IDLE; stall_o, dreq_o, dwe_o, wb_v_o, misalign_o = 0; daddr_o, dbe_o, dwdata_o, wb_rd_o, wb_data_o = 0.
- Op encoding:
  - Loads (minst_i[3]=0): LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores (minst_i[3]=1): SB 000, SH 001, SW 010.
  - Any other encoding is treated as no memory op.
- Acceptance: an op is accepted on any clock edge where state==IDLE; stall_o = (state != IDLE).
- Pass-through (no memory op):
  - If rdm_v_i and rd_i != 0: wb_v_o=1, wb_rd_o=rd_i, wb_data_o=addr_i on the next cycle.
  - Otherwise nothing happens.
- Misalignment check at acceptance:
  - H with addr[0]=1 is misaligned; W with addr[1:0] != 0 is misaligned.
  - Result: misalign_o pulses 1 cycle, no bus request, no writeback, state stays IDLE.
- Aligned mem op: all op fields are registered and the state goes to REQ.
- State REQ:
  - dreq_o=1; daddr_o, dwe_o, dbe_o, dwdata_o held stable until dgnt_i.
  - On dgnt_i: store goes to IDLE; load goes to RESP.
  - dreq_o drops the cycle after the grant.
- State RESP:
  - Waits for drvalid_i, then goes to IDLE.
  - The next cycle, if rd != 0: wb_v_o=1, wb_rd_o=rd, and wb_data_o = the selected lane, sign- or zero-extended per funct3.
- Lane rules:
  - Byte: dbe = 1 << addr[1:0]; data replicated/shifted by 8*addr[1:0].
  - Half: dbe = 2'b11 << addr[1:0]; shift by 8*addr[1:0].
  - Word: dbe = 4'hF.
  - Loads drive dbe_o with the same mask.
- Timing and boundaries:
  - Minimum occupancy is 2 cycles for a store and 3 cycles (accept + REQ + RESP) for a load.
  - drvalid_i outside RESP is ignored. dgnt_i outside REQ is ignored.
  - Reset mid-transaction returns to IDLE immediately. No writeback is produced and any late drvalid_i is ignored.
  - Bus protocol guarantees at most one outstanding request.
  - Load to x0 performs the bus access but produces no writeback.

Decomposition:
- Add to instruction_pkg:
  - memop funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - localparam MINST_NONE = 2'b11 (minst[3:2]).
  - enum mem_state_t {IDLE, REQ, RESP}.
- One sub-module is natural: mem_align, purely combinational.
  - Store side: dbe/dwdata generation and misalign detect.
  - Load side: lane extract and extension.
  - mem_access then holds only the FSM and registers.

Test Plan:
- Pass-through: minst=4'b1100, rdm_v=1, rd=5, addr=0x12345678 -> next cycle wb_v=1, wb_rd=5, wb_data=0x12345678; dreq never asserted; stall stays 0.
- LB sign-extend: minst=0000, addr=0x1003, rd=3, gnt in REQ, drdata=0x80112233 -> daddr=0x1000, dbe=1000, dwe=0; wb_data=0xFFFFFF80 the cycle after drvalid. LBU with the same data -> 0x00000080.
- SH lanes with 3-cycle grant delay: minst=1001, addr=0x2002, wdata=0x0000ABCD, dgnt held low 3 cycles -> dreq, daddr=0x2000, dbe=1100, dwdata=0xABCD0000 all stable 4 cycles; stall=1 throughout; no wb_v.
- Misalign: LW at addr=0x1001 -> misalign_o one cycle, dreq stays 0, no writeback, next op accepted the following cycle.
- Reset mid-load: assert reset while in RESP, then drvalid_i=1 afterward -> all outputs return to reset values; no wb_v; stall_o=0.
- Back-to-back: LW 0x3000 (drdata=0xDEADBEEF, rd=7) followed by pass-through op -> second op held by stall until IDLE; wb pulses in order: x7=0xDEADBEEF, then the pass-through result.
